bwn_acc_ctrl: RTL and testbench
===============================

BWN_ACC_CTRL -- requirements
Module: bwn_acc_ctrl

Interface
REQ-001 Parameter N_ACC, default 9: accumulate steps (taps) per output value, legal range 1 to 255.
REQ-002 Parameter N_OUT, default 16: output values per layer pass, legal range 1 to 255.
REQ-003 Parameter CW, default 8: width of the tap and output counters.
REQ-004 The port iCLK SHALL be an input, 1 bit wide, and is the only clock; all state is updated on its rising edge.
REQ-005 The port iRST_N SHALL be an input, 1 bit wide, and is the synchronous, active-low reset.
REQ-006 The port iGO SHALL be an input, 1 bit wide, and is a one-cycle pulse that starts a layer pass.
REQ-007 The port iABORT SHALL be an input, 1 bit wide, and cancels a pass in progress.
REQ-008 The port iVALID SHALL be an input, 1 bit wide, and marks upstream operand valid.
REQ-009 The port oREADY SHALL be an output, 1 bit wide, and marks the controller ready to accept an operand.
REQ-010 The port oCLR SHALL be an output, 1 bit wide, and drives the accumulator register's start/clear input.
REQ-011 The port oEN SHALL be an output, 1 bit wide, and drives the accumulator register's load enable.
REQ-012 The port oTAP SHALL be an output, CW bits wide, and gives the current tap index, used as the weight-bit select.
REQ-013 The port oOUT SHALL be an output, CW bits wide, and gives the current output index.
REQ-014 The port oVALID SHALL be an output, 1 bit wide, and marks the accumulated result ready for downstream.
REQ-015 The port iREADY SHALL be an input, 1 bit wide, and marks downstream accepting the result.
REQ-016 The port oDONE SHALL be an output, 1 bit wide, and is a one-cycle pulse marking the end of a layer pass.
REQ-017 The port oBUSY SHALL be an output, 1 bit wide, and is high in every state except IDLE.

Function
REQ-018 The FSM SHALL have exactly five states: IDLE, CLEAR, ACCUM, HOLD and FIN.
REQ-019 In IDLE, iGO=1 SHALL move the FSM to CLEAR; iGO SHALL be ignored in every other state.
REQ-020 CLEAR SHALL last exactly one cycle, assert oCLR=1, set the tap counter to 0 and then move to ACCUM.
REQ-021 In ACCUM, oREADY SHALL be 1 and oEN SHALL equal the combinational AND of iVALID and oREADY in the same cycle.
REQ-022 In ACCUM, each accepted operand (iVALID=1 with oREADY=1) SHALL increment oTAP by 1.
REQ-023 An accepted operand while oTAP equals N_ACC-1 SHALL move the FSM to HOLD and reset oTAP to 0.
REQ-024 In HOLD, oVALID SHALL be 1 and oREADY SHALL be 0, so that oVALID rises exactly 1 cycle after the last oEN.
REQ-025 In HOLD, iREADY=1 while oOUT is below N_OUT-1 SHALL increment oOUT and move the FSM to CLEAR.
REQ-026 In HOLD, iREADY=1 while oOUT equals N_OUT-1 SHALL move the FSM to FIN.
REQ-027 FIN SHALL last exactly one cycle, assert oDONE=1, reset oOUT to 0 and then move to IDLE.
REQ-028 oVALID SHALL remain high, with oOUT held stable, until iREADY=1; no data is dropped under backpressure.
REQ-029 oCLR, oEN and oDONE SHALL never be asserted in the same cycle.
REQ-030 iABORT=1 in any state SHALL take priority over every other input.
REQ-031 On iABORT, the next state SHALL be IDLE and both counters SHALL clear to 0.
REQ-032 The abort cycle itself SHALL assert oCLR=1, oEN=0 and oDONE=0.
REQ-033 The latency from the iGO pulse to oREADY=1 SHALL be 2 cycles.
REQ-034 With N_ACC=1, every accepted operand SHALL go directly to HOLD.
REQ-035 Counter compares SHALL use CW-bit unsigned arithmetic; counters SHALL never exceed their limit minus 1.

Reset
REQ-036 With iRST_N=0 at a rising iCLK edge, the state SHALL become IDLE.
REQ-037 Reset SHALL set oTAP and oOUT to 0.
REQ-038 Reset SHALL drive oREADY, oCLR, oEN, oVALID, oDONE and oBUSY to 0.
REQ-039 The performance counter of REQ-041 SHALL reset to 0.
REQ-040 Reset asserted mid-pass SHALL behave as iABORT, except that oCLR stays 0.

Configuration
REQ-041 With macro BWN_ACC_PERF_EN defined, output oSTALL_CNT (16 bits) SHALL count cycles spent in ACCUM with iVALID=0 plus cycles spent in HOLD with iREADY=0.
REQ-042 oSTALL_CNT SHALL saturate at 16'hFFFF and SHALL clear to 0 on the iGO that starts a pass.
REQ-043 Without BWN_ACC_PERF_EN, the oSTALL_CNT port and its logic SHALL be absent; all other behaviour SHALL be identical.

Structure
REQ-044 Package bwn_ctrl_pkg SHALL hold the state enum type and the default N_ACC/N_OUT constants.
REQ-045 Sub-module bwn_mod_cnt (modulo-N counter with clear, increment and wrap flag) SHALL be instantiated twice, once for taps and once for outputs.

Verification (N_ACC=3, N_OUT=2 unless stated)
REQ-046 Basic pass: iGO, then iVALID held 1 and iREADY held 1 -> oCLR in cycle 1, oEN in cycles 2-4 with oTAP 0,1,2, oVALID in cycle 5 with oOUT=0, oVALID in cycle 10 with oOUT=1, oDONE in cycle 11.
REQ-047 Input bubbles: iVALID pattern 1,0,0,1,1 -> exactly 3 oEN pulses, oTAP skips no value, and oSTALL_CNT=2 with the macro defined.
REQ-048 Backpressure: iREADY=0 for 4 cycles in HOLD -> oVALID held for 5 cycles, oOUT stable, no oCLR until the iREADY handshake.
REQ-049 Abort in ACCUM with oTAP=1 -> next cycle IDLE with oTAP=0, oOUT=0, oDONE never asserted; a following iGO runs a full clean pass.
REQ-050 Sync reset: iRST_N=0 for 1 cycle mid-HOLD -> all outputs 0 at the next edge; iGO during reset is ignored.
REQ-051 Degenerate configuration N_ACC=1, N_OUT=1 -> the sequence oCLR, oEN, oVALID, oDONE runs on consecutive cycles with iVALID=1 and iREADY=1.

Source files
------------

// File: rtl/bwn_ctrl_pkg.sv
// bwn_ctrl_pkg: shared types and defaults for the BWN accumulator controller.
//   state_t   - controller state encoding (IDLE, CLEAR, ACCUM, HOLD, FIN)
//   N_ACC_DEF - default accumulate steps (taps) per output value
//   N_OUT_DEF - default output values per layer pass
package bwn_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_ACCUM,
    S_HOLD,
    S_FIN
  } state_t;

  localparam int unsigned N_ACC_DEF = 9;
  localparam int unsigned N_OUT_DEF = 16;

endpackage

// File: rtl/bwn_mod_cnt.sv
// bwn_mod_cnt: modulo-N counter with synchronous clear, increment and wrap flag.
//   clk   - clock, rising edge
//   rst_n - synchronous active-low reset (count -> 0)
//   clr   - synchronous clear, wins over inc
//   inc   - advance by one; wraps to 0 after N-1
//   cnt   - current count, CW bits
//   last  - high while cnt equals N-1
module bwn_mod_cnt #(
  parameter int unsigned N  = 9,
  parameter int unsigned CW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          inc,
  output logic [CW-1:0] cnt,
  output logic          last
);

  localparam logic [CW-1:0] LIM = CW'(N - 1);

  assign last = (cnt == LIM);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= last ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/bwn_acc_ctrl.sv
// bwn_acc_ctrl: sequencing controller for a binary-weight accumulator.
// A pass (started by iGO) produces N_OUT results, each built from N_ACC
// accepted operands, with a valid/ready handshake on both sides.
//   iCLK, iRST_N      - clock and synchronous active-low reset
//   iGO, iABORT       - start a pass / cancel a pass (abort has top priority)
//   iVALID, oREADY    - upstream operand handshake
//   oCLR, oEN         - accumulator clear and load enable
//   oTAP, oOUT        - tap (weight-bit select) and output indices
//   oVALID, iREADY    - downstream result handshake
//   oDONE, oBUSY      - end-of-pass pulse, not-idle flag
//   oSTALL_CNT        - stall cycle counter, present only with BWN_ACC_PERF_EN
module bwn_acc_ctrl
  import bwn_ctrl_pkg::*;
#(
  parameter int unsigned N_ACC = N_ACC_DEF,
  parameter int unsigned N_OUT = N_OUT_DEF,
  parameter int unsigned CW    = 8
) (
  input  logic          iCLK,
  input  logic          iRST_N,
  input  logic          iGO,
  input  logic          iABORT,
  input  logic          iVALID,
  output logic          oREADY,
  output logic          oCLR,
  output logic          oEN,
  output logic [CW-1:0] oTAP,
  output logic [CW-1:0] oOUT,
  output logic          oVALID,
  input  logic          iREADY,
  output logic          oDONE,
  output logic          oBUSY
`ifdef BWN_ACC_PERF_EN
  ,
  output logic [15:0]   oSTALL_CNT
`endif
);

  state_t state, state_n;
  logic   tap_last, out_last;
  logic   tap_clr, out_clr, out_inc;

  always_ff @(posedge iCLK) begin
    if (!iRST_N) begin
      state <= S_IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:  if (iGO) state_n = S_CLEAR;
      S_CLEAR: state_n = S_ACCUM;
      S_ACCUM: if (iVALID && tap_last) state_n = S_HOLD;
      S_HOLD:  if (iREADY) state_n = out_last ? S_FIN : S_CLEAR;
      S_FIN:   state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
    if (iABORT) state_n = S_IDLE;
  end

  // Strobes are masked during the reset cycle so a mid-pass reset never
  // clears or loads the accumulator; ready is masked on abort so that
  // oEN stays exactly iVALID & oREADY.
  always_comb begin
    oREADY = iRST_N && !iABORT && (state == S_ACCUM);
    oEN    = oREADY && iVALID;
    oCLR   = iRST_N && (iABORT || (state == S_CLEAR));
    oDONE  = iRST_N && !iABORT && (state == S_FIN);
    oVALID = (state == S_HOLD);
    oBUSY  = (state != S_IDLE);
  end

  assign tap_clr = iABORT || (state == S_CLEAR);
  assign out_clr = iABORT || (state == S_FIN);
  // The output index stays at N_OUT-1 through FIN and is cleared there.
  assign out_inc = (state == S_HOLD) && iREADY && !out_last;

  bwn_mod_cnt #(.N(N_ACC), .CW(CW)) u_tap_cnt (
    .clk   (iCLK),
    .rst_n (iRST_N),
    .clr   (tap_clr),
    .inc   (oEN),
    .cnt   (oTAP),
    .last  (tap_last)
  );

  bwn_mod_cnt #(.N(N_OUT), .CW(CW)) u_out_cnt (
    .clk   (iCLK),
    .rst_n (iRST_N),
    .clr   (out_clr),
    .inc   (out_inc),
    .cnt   (oOUT),
    .last  (out_last)
  );

`ifdef BWN_ACC_PERF_EN
  always_ff @(posedge iCLK) begin
    if (!iRST_N) begin
      oSTALL_CNT <= '0;
    end else if ((state == S_IDLE) && iGO && !iABORT) begin
      oSTALL_CNT <= '0;
    end else if ((((state == S_ACCUM) && !iVALID) || ((state == S_HOLD) && !iREADY))
                 && (oSTALL_CNT != '1)) begin
      oSTALL_CNT <= oSTALL_CNT + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_bwn_acc_ctrl.sv
module tb_bwn_acc_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n [2];
  logic       go    [2];
  logic       abort [2];
  logic       vin   [2];
  logic       rin   [2];
  logic       rdy_o [2];
  logic       clr_o [2];
  logic       en_o  [2];
  logic       val_o [2];
  logic       done_o[2];
  logic       busy_o[2];
  logic [7:0] tap_o [2];
  logic [7:0] out_o [2];
`ifdef BWN_ACC_PERF_EN
  logic [15:0] stall_o[2];
`endif

  int checks = 0;
  int errors = 0;
  bit cmp_en = 0;

  bwn_acc_ctrl #(.N_ACC(3), .N_OUT(2), .CW(8)) dut (
    .iCLK(clk), .iRST_N(rst_n[0]), .iGO(go[0]), .iABORT(abort[0]),
    .iVALID(vin[0]), .oREADY(rdy_o[0]), .oCLR(clr_o[0]), .oEN(en_o[0]),
    .oTAP(tap_o[0]), .oOUT(out_o[0]), .oVALID(val_o[0]), .iREADY(rin[0]),
    .oDONE(done_o[0]), .oBUSY(busy_o[0])
`ifdef BWN_ACC_PERF_EN
    , .oSTALL_CNT(stall_o[0])
`endif
  );

  bwn_acc_ctrl #(.N_ACC(1), .N_OUT(1), .CW(8)) dut1 (
    .iCLK(clk), .iRST_N(rst_n[1]), .iGO(go[1]), .iABORT(abort[1]),
    .iVALID(vin[1]), .oREADY(rdy_o[1]), .oCLR(clr_o[1]), .oEN(en_o[1]),
    .oTAP(tap_o[1]), .oOUT(out_o[1]), .oVALID(val_o[1]), .iREADY(rin[1]),
    .oDONE(done_o[1]), .oBUSY(busy_o[1])
`ifdef BWN_ACC_PERF_EN
    , .oSTALL_CNT(stall_o[1])
`endif
  );

  function automatic int na(input int i);
    return (i == 0) ? 3 : 1;
  endfunction

  function automatic int no(input int i);
    return (i == 0) ? 2 : 1;
  endfunction

  // Reference model in pass terms: a pass is active, a clear is pending,
  // k operands have been taken for the current result (k == N_ACC means
  // the result is waiting for downstream), j results have been delivered.
  bit m_pass[2], m_clr[2], m_fin[2];
  int m_k[2], m_j[2], m_stall[2];

  task automatic chk(input string name, input int i, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d] got %0h expected %0h at %0t", name, i, act, exp, $time);
    end
  endtask

  task automatic model_step(input int i);
    bit act, acc, hold;
    act  = m_pass[i] && !m_clr[i] && !m_fin[i];
    acc  = act && (m_k[i] < na(i));
    hold = act && (m_k[i] == na(i));
    if (!rst_n[i]) begin
      m_pass[i] = 0; m_clr[i] = 0; m_fin[i] = 0;
      m_k[i] = 0; m_j[i] = 0; m_stall[i] = 0;
      return;
    end
    if (!m_pass[i] && go[i] && !abort[i]) m_stall[i] = 0;
    else if ((acc && !vin[i]) || (hold && !rin[i])) begin
      if (m_stall[i] < 65535) m_stall[i]++;
    end
    if (abort[i]) begin
      m_pass[i] = 0; m_clr[i] = 0; m_fin[i] = 0; m_k[i] = 0; m_j[i] = 0;
    end else if (m_fin[i]) begin
      m_fin[i] = 0; m_pass[i] = 0; m_j[i] = 0;
    end else if (!m_pass[i]) begin
      if (go[i]) begin m_pass[i] = 1; m_clr[i] = 1; m_k[i] = 0; end
    end else if (m_clr[i]) begin
      m_clr[i] = 0;
    end else if (m_k[i] < na(i)) begin
      if (vin[i]) m_k[i]++;
    end else if (rin[i]) begin
      m_k[i] = 0;
      if (m_j[i] == no(i) - 1) m_fin[i] = 1;
      else begin m_j[i]++; m_clr[i] = 1; end
    end
  endtask

  task automatic check_inst(input int i);
    bit rs, ab, act, acc, hold;
    int ntr;
    rs   = rst_n[i];
    ab   = abort[i];
    act  = m_pass[i] && !m_clr[i] && !m_fin[i];
    acc  = act && (m_k[i] < na(i));
    hold = act && (m_k[i] == na(i));
    chk("oCLR",   i, clr_o[i],  rs && (ab || (m_pass[i] && m_clr[i])));
    chk("oREADY", i, rdy_o[i],  rs && !ab && acc);
    chk("oEN",    i, en_o[i],   rs && !ab && acc && vin[i]);
    chk("oVALID", i, val_o[i],  hold);
    chk("oDONE",  i, done_o[i], rs && !ab && m_fin[i]);
    chk("oBUSY",  i, busy_o[i], m_pass[i]);
    chk("oTAP",   i, tap_o[i],  hold ? 0 : m_k[i]);
    chk("oOUT",   i, out_o[i],  m_j[i]);
    ntr = int'(clr_o[i]) + int'(en_o[i]) + int'(done_o[i]);
    chk("strobe_excl", i, ntr <= 1, 1);
`ifdef BWN_ACC_PERF_EN
    chk("oSTALL_CNT", i, stall_o[i], m_stall[i]);
`endif
  endtask

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) model_step(i);
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      for (int i = 0; i < 2; i++) check_inst(i);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic force_idle(input int i);
    abort[i] = 1; go[i] = 0; vin[i] = 0; rin[i] = 0;
    tick();
    abort[i] = 0;
  endtask

  task automatic wait_valid0(input string name);
    int n;
    n = 0;
    while (val_o[0] !== 1'b1 && n < 30) begin
      tick();
      n++;
    end
    chk(name, 0, val_o[0], 1);
  endtask

  initial begin
    int pat[5];
    int en_cnt, taps_seen, vcnt, n;
    pat = '{1, 0, 0, 1, 1};
    for (int i = 0; i < 2; i++) begin
      rst_n[i] = 0; go[i] = 0; abort[i] = 0; vin[i] = 0; rin[i] = 0;
    end
    @(posedge clk);
    #1;
    cmp_en = 1;
    @(negedge clk);
    chk("rst_busy", 0, busy_o[0], 0);
    chk("rst_tap",  0, tap_o[0], 0);
    chk("rst_out",  1, out_o[1], 0);
    tick();
    rst_n[0] = 1; rst_n[1] = 1;
    tick();

    // Basic pass, N_ACC=3 N_OUT=2
    go[0] = 1; vin[0] = 1; rin[0] = 1;
    for (int c = 0; c <= 12; c++) begin
      @(negedge clk);
      chk("b_clr",   0, clr_o[0],  c == 1 || c == 6);
      chk("b_en",    0, en_o[0],   (c >= 2 && c <= 4) || (c >= 7 && c <= 9));
      chk("b_valid", 0, val_o[0],  c == 5 || c == 10);
      chk("b_done",  0, done_o[0], c == 11);
      if (c >= 2 && c <= 4) chk("b_tap", 0, tap_o[0], c - 2);
      if (c == 5)  chk("b_out", 0, out_o[0], 0);
      if (c == 10) chk("b_out", 0, out_o[0], 1);
      tick();
      go[0] = 0;
    end
    force_idle(0);

    // Degenerate N_ACC=1 N_OUT=1
    go[1] = 1; vin[1] = 1; rin[1] = 1;
    for (int c = 0; c <= 5; c++) begin
      @(negedge clk);
      chk("d_clr",   1, clr_o[1],  c == 1);
      chk("d_en",    1, en_o[1],   c == 2);
      chk("d_valid", 1, val_o[1],  c == 3);
      chk("d_done",  1, done_o[1], c == 4);
      tick();
      go[1] = 0;
    end
    force_idle(1);

    // Input bubbles
    en_cnt = 0; taps_seen = 0;
    go[0] = 1; rin[0] = 1;
    for (int c = 0; c <= 7; c++) begin
      vin[0] = (c >= 2 && c <= 6) ? pat[c-2][0] : 1'b0;
      @(negedge clk);
      if (en_o[0] === 1'b1) begin
        chk("bub_tap", 0, tap_o[0], taps_seen);
        taps_seen++;
        en_cnt++;
      end
      if (c == 7) begin
        chk("bub_valid", 0, val_o[0], 1);
`ifdef BWN_ACC_PERF_EN
        chk("bub_stall", 0, stall_o[0], 2);
`endif
      end
      tick();
      go[0] = 0;
    end
    chk("bub_en_count", 0, en_cnt, 3);
    force_idle(0);

    // Backpressure in HOLD
    go[0] = 1; vin[0] = 1; rin[0] = 0;
    tick();
    go[0] = 0;
    wait_valid0("bp_wait_valid");
    vcnt = 0;
    for (int c = 0; c <= 4; c++) begin
      @(negedge clk);
      if (val_o[0] === 1'b1) vcnt++;
      chk("bp_out", 0, out_o[0], 0);
      chk("bp_clr", 0, clr_o[0], 0);
      tick();
      if (c == 3) rin[0] = 1;
    end
    @(negedge clk);
    chk("bp_clr_after", 0, clr_o[0], 1);
    chk("bp_valid_cycles", 0, vcnt, 5);
    tick();
    force_idle(0);

    // Abort in ACCUM with tap 1, then a clean pass
    go[0] = 1; vin[0] = 1; rin[0] = 1;
    tick();
    go[0] = 0;
    tick();
    tick();
    abort[0] = 1;
    @(negedge clk);
    chk("ab_tap",  0, tap_o[0], 1);
    chk("ab_clr",  0, clr_o[0], 1);
    chk("ab_en",   0, en_o[0], 0);
    chk("ab_done", 0, done_o[0], 0);
    tick();
    abort[0] = 0;
    @(negedge clk);
    chk("ab_busy", 0, busy_o[0], 0);
    chk("ab_tap0", 0, tap_o[0], 0);
    chk("ab_out0", 0, out_o[0], 0);
    tick();
    go[0] = 1;
    tick();
    go[0] = 0;
    n = 0;
    while (done_o[0] !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    chk("ab_rerun_done", 0, done_o[0], 1);
    chk("ab_rerun_out", 0, out_o[0], 1);
    tick();

    // Synchronous reset mid-HOLD, iGO during reset ignored
    go[0] = 1; vin[0] = 1; rin[0] = 0;
    tick();
    go[0] = 0;
    wait_valid0("rs_wait_valid");
    rst_n[0] = 0; go[0] = 1;
    tick();
    rst_n[0] = 1; go[0] = 0;
    @(negedge clk);
    chk("rs_busy",  0, busy_o[0], 0);
    chk("rs_valid", 0, val_o[0], 0);
    chk("rs_clr",   0, clr_o[0], 0);
    chk("rs_tap",   0, tap_o[0], 0);
    chk("rs_out",   0, out_o[0], 0);
    tick();
    @(negedge clk);
    chk("rs_go_ignored", 0, busy_o[0], 0);
    tick();

    // Randomized traffic on both instances
    for (int c = 0; c < 4000; c++) begin
      for (int i = 0; i < 2; i++) begin
        rst_n[i] = ($urandom_range(0, 299) != 0);
        go[i]    = ($urandom_range(0, 7) == 0);
        abort[i] = ($urandom_range(0, 79) == 0);
        vin[i]   = ($urandom_range(0, 9) < 6);
        rin[i]   = (c < 2000) ? ($urandom_range(0, 9) < 6) : ($urandom_range(0, 9) < 2);
      end
      tick();
    end

    cmp_en = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
